// File: rtl/fabric_stream_gen.sv
// Valid/ready token source: emits COUNT tokens base, base+stride, ... with a fixed tag,
// holding each token stable under backpressure until it is accepted.
module fabric_stream_gen #(
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [2*DATA_WIDTH+COUNT_WIDTH+TAG_WIDTH-1:0] cfg_data,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0]               out_data
);

    generate
        if (DATA_WIDTH < 1) begin : g_bad_type
            $fatal(1, "CPL_STREAM_GEN_INVALID_TYPE: DATA_WIDTH must be at least 1");
        end
        if (TAG_WIDTH < 0 || TAG_WIDTH > 16) begin : g_bad_tag
            $fatal(1, "CPL_STREAM_GEN_INVALID_TAG: TAG_WIDTH must be 0..16");
        end
        if (COUNT_WIDTH < 1) begin : g_bad_count
            $fatal(1, "CPL_STREAM_GEN_INVALID_COUNT: COUNT_WIDTH must be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  value_q, value_d;
    logic [DATA_WIDTH-1:0]  stride_q, stride_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic                   done_q, done_d;

    logic [DATA_WIDTH-1:0]  cfg_base;
    logic [DATA_WIDTH-1:0]  cfg_stride;
    logic [COUNT_WIDTH-1:0] cfg_count;
    logic                   load;
    logic                   handshake;

    assign cfg_base   = cfg_data[DATA_WIDTH-1:0];
    assign cfg_stride = cfg_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign cfg_count  = cfg_data[2*DATA_WIDTH+COUNT_WIDTH-1:2*DATA_WIDTH];

    // start is only honoured from IDLE, so requests while busy simply fall away.
    assign load      = (state_q == IDLE) && start;
    assign handshake = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    value_d  = cfg_base;
                    stride_d = cfg_stride;
                    rem_d    = cfg_count;
                    if (cfg_count != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    value_d = value_q + stride_q;
                    rem_d   = rem_q - COUNT_WIDTH'(1);
                    if (rem_q == COUNT_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            value_q  <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
        end
    end

    // Valid is a pure function of state, so it can never follow out_ready combinationally.
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = done_q;

    generate
        if (TAG_WIDTH > 0) begin : g_tag
            logic [TAG_WIDTH-1:0] tag_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_q <= '0;
                end else if (load) begin
                    tag_q <= cfg_data[2*DATA_WIDTH+COUNT_WIDTH+TAG_WIDTH-1:2*DATA_WIDTH+COUNT_WIDTH];
                end
            end

            assign out_data = out_valid ? {tag_q, value_q} : '0;
        end else begin : g_notag
            assign out_data = out_valid ? value_q : '0;
        end
    endgenerate

    // handshake is kept as a named term for readability of waveforms.
    logic unused_handshake;
    assign unused_handshake = handshake;

endmodule
